// File: rtl/muldiv_hilo_unit.sv
// HI/LO register pair with a multi-cycle multiplier and a restoring divider behind a valid/ready port.
// Define MULDIV_ACCUMULATE_EN to enable MADD/MSUB; otherwise ops 6/7 are accepted as no-ops.
module muldiv_hilo_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  request_valid,
   output logic                  request_ready,
   input  logic [2:0]            request_op,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic                  cancel,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] high_data,
   output logic [DATA_WIDTH-1:0] low_data
);
   localparam int DW      = DATA_WIDTH;
   localparam int CNT_MAX = (DW > MUL_LATENCY) ? DW : MUL_LATENCY;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;
   typedef enum logic [2:0] {
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MSUB
   } op_t;

   state_t          state;
   op_t             op_q;
   op_t             req_op;
   logic [DW-1:0]   a_q, b_q;
   logic [DW-1:0]   div_b_q, quo_q, rem_q;
   logic [CNT_W-1:0] count;

   logic            accept;
   logic            req_signed_div;
   logic [DW-1:0]   a_mag, b_mag;
   logic [2*DW-1:0] ext_a, ext_b, product, mul_result;
   logic [DW:0]     div_shift, div_trial;
   logic            q_neg, r_neg;
   logic [DW-1:0]   fix_lo, fix_hi;

   assign req_op        = op_t'(request_op);
   assign request_ready = (state == ST_IDLE) && !cancel;
   assign busy          = (state != ST_IDLE);
   assign accept        = request_valid && request_ready;

   // The divider iterates on magnitudes; signs are re-applied in FIX from the latched operands.
   assign req_signed_div = (req_op == OP_DIV);
   assign a_mag = (req_signed_div && operand_a[DW-1]) ? -operand_a : operand_a;
   assign b_mag = (req_signed_div && operand_b[DW-1]) ? -operand_b : operand_b;

   assign ext_a   = (op_q == OP_MULTU) ? {{DW{1'b0}}, a_q} : {{DW{a_q[DW-1]}}, a_q};
   assign ext_b   = (op_q == OP_MULTU) ? {{DW{1'b0}}, b_q} : {{DW{b_q[DW-1]}}, b_q};
   assign product = ext_a * ext_b;

   always_comb begin
      // NOTE: every always_comb output is given a default first, so no path can infer a latch.
      mul_result = product;
`ifdef MULDIV_ACCUMULATE_EN
      if (op_q == OP_MADD)      mul_result = {high_data, low_data} + product;
      else if (op_q == OP_MSUB) mul_result = {high_data, low_data} - product;
`endif
   end

   assign div_shift = {rem_q, quo_q[DW-1]};
   assign div_trial = div_shift - {1'b0, div_b_q};

   always_comb begin
      q_neg  = (op_q == OP_DIV) && (a_q[DW-1] ^ b_q[DW-1]);
      r_neg  = (op_q == OP_DIV) && a_q[DW-1];
      fix_lo = q_neg ? -quo_q : quo_q;
      fix_hi = r_neg ? -rem_q : rem_q;
      if (b_q == '0) begin
         fix_lo = '1;
         fix_hi = a_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         op_q      <= OP_MULT;
         a_q       <= '0;
         b_q       <= '0;
         div_b_q   <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         count     <= '0;
         done      <= 1'b0;
         high_data <= '0;
         low_data  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         done <= 1'b0;
         if (cancel && state != ST_IDLE) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     op_q  <= req_op;
                     a_q   <= operand_a;
                     b_q   <= operand_b;
                     count <= '0;
                     case (req_op)
                        OP_MULT, OP_MULTU: state <= ST_MUL;
                        OP_DIV, OP_DIVU: begin
                           state   <= ST_DIV;
                           rem_q   <= '0;
                           quo_q   <= a_mag;
                           div_b_q <= b_mag;
                        end
                        OP_MTHI: begin
                           high_data <= operand_a;
                           done      <= 1'b1;
                        end
                        OP_MTLO: begin
                           low_data <= operand_a;
                           done     <= 1'b1;
                        end
`ifdef MULDIV_ACCUMULATE_EN
                        OP_MADD, OP_MSUB: state <= ST_MUL;
`endif
                        default: ;
                     endcase
                  end
               end
               ST_MUL: begin
                  if (count == CNT_W'(MUL_LATENCY - 1)) begin
                     {high_data, low_data} <= mul_result;
                     done                  <= 1'b1;
                     state                 <= ST_IDLE;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               ST_DIV: begin
                  if (!div_trial[DW]) begin
                     rem_q <= div_trial[DW-1:0];
                     quo_q <= {quo_q[DW-2:0], 1'b1};
                  end else begin
                     rem_q <= div_shift[DW-1:0];
                     quo_q <= {quo_q[DW-2:0], 1'b0};
                  end
                  if (count == CNT_W'(DW - 1)) state <= ST_FIX;
                  else                          count <= count + 1'b1;
               end
               ST_FIX: begin
                  low_data  <= fix_lo;
                  high_data <= fix_hi;
                  done      <= 1'b1;
                  state     <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: vector table through a scoreboard, then cancel/reset sequences.
module tb_muldiv_hilo_unit;
   localparam int DW      = 32;
   localparam int LAT     = 2;
   localparam int DIV_LAT = DW + 1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MSUB  = 3'd7;

   logic          clock;
   logic          reset_n;
   logic          request_valid;
   logic          request_ready;
   logic [2:0]    request_op;
   logic [DW-1:0] operand_a;
   logic [DW-1:0] operand_b;
   logic          cancel;
   logic          busy;
   logic          done;
   logic [DW-1:0] high_data;
   logic [DW-1:0] low_data;

   muldiv_hilo_unit #(.DATA_WIDTH(DW), .MUL_LATENCY(LAT)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .request_valid (request_valid),
      .request_ready (request_ready),
      .request_op    (request_op),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .cancel        (cancel),
      .busy          (busy),
      .done          (done),
      .high_data     (high_data),
      .low_data      (low_data)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [2:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] exp_hi;
      logic [DW-1:0] exp_lo;
      int            exp_lat;
   } vec_t;

   typedef struct {
      logic [DW-1:0] hi;
      logic [DW-1:0] lo;
      int            lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic add_vec(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] hi, input logic [DW-1:0] lo, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp_hi = hi; v.exp_lo = lo; v.exp_lat = lat;
      vecs.push_back(v);
   endtask

   // Leaves the caller 1 time unit after the accept edge.
   task automatic drive_req(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      int w;
      w = 0;
      while (!request_ready && w < 100) begin
         tick();
         w++;
      end
      if (w >= 100) check("ready_wait_timeout", 64'(request_ready), 64'(1));
      request_valid = 1'b1;
      request_op    = op;
      operand_a     = a;
      operand_b     = b;
      tick();
      request_valid = 1'b0;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      exp_t e;
      int   cyc, rdy_low, busy_hi;
      v = vecs[idx];
      e.hi = v.exp_hi; e.lo = v.exp_lo; e.lat = v.exp_lat;
      sb.push_back(e);
      drive_req(v.op, v.a, v.b);
      cyc = 0; rdy_low = 0; busy_hi = 0;
      while (!done && cyc < 200) begin
         if (!request_ready) rdy_low++;
         if (busy) busy_hi++;
         tick();
         cyc++;
      end
      e = sb.pop_front();
      check($sformatf("v%0d_done", idx), 64'(done), 64'(1));
      check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(e.lat));
      check($sformatf("v%0d_ready_low_cycles", idx), 64'(rdy_low), 64'(e.lat));
      check($sformatf("v%0d_busy_cycles", idx), 64'(busy_hi), 64'(e.lat));
      check($sformatf("v%0d_ready_at_done", idx), 64'(request_ready), 64'(1));
      check($sformatf("v%0d_hi", idx), 64'(high_data), 64'(e.hi));
      check($sformatf("v%0d_lo", idx), 64'(low_data), 64'(e.lo));
      tick();
      check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'(0));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_seen;
      reset_n       = 1'b0;
      request_valid = 1'b0;
      request_op    = '0;
      operand_a     = '0;
      operand_b     = '0;
      cancel        = 1'b0;

      //          op        a             b             exp_hi        exp_lo        latency
      add_vec(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, LAT);
      add_vec(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, LAT);
      add_vec(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, LAT);
      add_vec(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT);
      add_vec(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
      add_vec(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT);
      add_vec(OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, DIV_LAT);
      add_vec(OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, DIV_LAT);
      add_vec(OP_MTLO,  32'd9,        32'd0,        32'hFFFFFFFB, 32'd9,        0);
      add_vec(OP_MTHI,  32'h0000ABCD, 32'd0,        32'h0000ABCD, 32'd9,        0);
      add_vec(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_LAT);
      add_vec(OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, DIV_LAT);
      add_vec(OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        DIV_LAT);
      add_vec(OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        LAT);
`ifdef MULDIV_ACCUMULATE_EN
      add_vec(OP_MTHI,  32'd0,        32'd0,        32'd0,        32'd0,        0);
      add_vec(OP_MTLO,  32'd5,        32'd0,        32'd0,        32'd5,        0);
      add_vec(OP_MADD,  32'd3,        32'd4,        32'd0,        32'd17,       LAT);
      add_vec(OP_MSUB,  32'd3,        32'd4,        32'd0,        32'd5,        LAT);
      add_vec(OP_MSUB,  32'd2,        32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, LAT);
      add_vec(OP_MADD,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0,        32'd5,        LAT);
      add_vec(OP_MTLO,  32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 0);
      add_vec(OP_MADD,  32'd1,        32'd1,        32'd1,        32'd0,        LAT);
`endif

      repeat (3) @(posedge clock);
      #1;
      check("reset_hi", 64'(high_data), 64'(0));
      check("reset_lo", 64'(low_data), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      reset_n = 1'b1;
      #1;
      check("ready_after_reset", 64'(request_ready), 64'(1));

      for (int i = 0; i < vecs.size(); i++) run_vec(i);

      // Preload HI=LO=0x55, then cancel a divide mid-way.
      drive_req(OP_MTHI, 32'h55, 32'd0);
      drive_req(OP_MTLO, 32'h55, 32'd0);
      check("preload_hi", 64'(high_data), 64'(32'h55));
      check("preload_lo", 64'(low_data), 64'(32'h55));
      drive_req(OP_DIV, 32'd100, 32'd7);
      repeat (9) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      #1;
      check("cancel_mid_busy", 64'(busy), 64'(0));
      check("cancel_mid_ready", 64'(request_ready), 64'(1));
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) done_seen++;
         tick();
      end
      check("cancel_mid_no_done", 64'(done_seen), 64'(0));
      check("cancel_mid_hi", 64'(high_data), 64'(32'h55));
      check("cancel_mid_lo", 64'(low_data), 64'(32'h55));

      // Cancel on the FIX cycle: the would-be completion edge must not write.
      drive_req(OP_DIVU, 32'd100, 32'd7);
      repeat (DW) tick();
      check("fix_cycle_busy", 64'(busy), 64'(1));
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      #1;
      check("cancel_fix_done", 64'(done), 64'(0));
      check("cancel_fix_busy", 64'(busy), 64'(0));
      check("cancel_fix_hi", 64'(high_data), 64'(32'h55));
      check("cancel_fix_lo", 64'(low_data), 64'(32'h55));
      tick();
      check("cancel_fix_done_late", 64'(done), 64'(0));

      // Cancel in IDLE blocks acceptance.
      cancel        = 1'b1;
      request_valid = 1'b1;
      request_op    = OP_MTLO;
      operand_a     = 32'h77;
      #1;
      check("cancel_idle_ready", 64'(request_ready), 64'(0));
      tick();
      request_valid = 1'b0;
      cancel        = 1'b0;
      #1;
      check("cancel_idle_done", 64'(done), 64'(0));
      check("cancel_idle_lo", 64'(low_data), 64'(32'h55));

      // Asynchronous reset mid-divide.
      drive_req(OP_DIV, 32'd100, 32'd7);
      repeat (5) tick();
      reset_n = 1'b0;
      #1;
      check("async_reset_hi", 64'(high_data), 64'(0));
      check("async_reset_lo", 64'(low_data), 64'(0));
      check("async_reset_busy", 64'(busy), 64'(0));
      check("async_reset_done", 64'(done), 64'(0));
      tick();
      reset_n = 1'b1;
      #1;
      check("ready_after_async_reset", 64'(request_ready), 64'(1));

`ifndef MULDIV_ACCUMULATE_EN
      // MADD/MSUB are accepted as no-ops in this build.
      drive_req(OP_MTHI, 32'h66, 32'd0);
      drive_req(OP_MADD, 32'd3, 32'd4);
      check("madd_noop_busy", 64'(busy), 64'(0));
      check("madd_noop_ready", 64'(request_ready), 64'(1));
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) done_seen++;
         tick();
      end
      drive_req(OP_MSUB, 32'd3, 32'd4);
      for (int i = 0; i < 5; i++) begin
         if (done) done_seen++;
         tick();
      end
      check("madd_msub_noop_done", 64'(done_seen), 64'(0));
      check("madd_noop_hi", 64'(high_data), 64'(32'h66));
      check("madd_noop_lo", 64'(low_data), 64'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
